// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier controller:
// FSM state encodings, accumulate-term selects and the partial-product order.
package mult_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      P0   = 3'd2,
      P1   = 3'd3,
      P2   = 3'd4,
      P3   = 3'd5,
      DONE = 3'd6
   } state_e;

   localparam logic [1:0] SEL_ZERO = 2'd0;
   localparam logic [1:0] SEL_SHL4 = 2'd1;
   localparam logic [1:0] SEL_SHL2 = 2'd2;
   localparam logic [1:0] SEL_NOSH = 2'd3;

   typedef struct packed {
      logic       a_sel;
      logic       b_sel;
      logic [1:0] ans_sel;
   } pp_step_t;

   // Low-first order LL, LH, HL, HH; the high-first order walks it backwards.
   localparam pp_step_t [0:3] PP_ORDER = {
      1'b0, 1'b0, SEL_NOSH,
      1'b0, 1'b1, SEL_SHL2,
      1'b1, 1'b0, SEL_SHL2,
      1'b1, 1'b1, SEL_SHL4
   };

endpackage

// File: rtl/mult4_4_ctrl.sv
// Sequencer for a 2-bit-slice 4x4 multiplier: clears the accumulator, then
// steps through the four partial products and pulses done.
module mult4_4_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter bit HI_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       Asel,
   output logic       Bsel,
   output logic [1:0] ans_sel,
   output logic       acc_clr,
   output logic       busy,
   output logic       done,
   output logic [7:0] ops_done
);

   state_e     state_q, state_d;
   logic [7:0] ops_done_q, ops_done_d;
   logic       in_pp;
   logic [1:0] pp_idx;
   pp_step_t   step;

   function automatic pp_step_t order_step(input logic [1:0] idx);
      return HI_FIRST ? PP_ORDER[2'd3 - idx] : PP_ORDER[idx];
   endfunction

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of process order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ops_done_q <= '0;
      end else begin
         state_q    <= state_d;
         ops_done_q <= ops_done_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      ops_done_d = ops_done_q;
      in_pp      = 1'b0;
      pp_idx     = 2'd0;
      step       = '0;
      Asel       = 1'b0;
      Bsel       = 1'b0;
      ans_sel    = SEL_ZERO;
      acc_clr    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         IDLE: if (start) state_d = CLR;
         CLR: begin
            acc_clr = 1'b1;
            busy    = 1'b1;
            state_d = abort ? IDLE : P0;
         end
         P0: begin in_pp = 1'b1; pp_idx = 2'd0; state_d = abort ? IDLE : P1;   end
         P1: begin in_pp = 1'b1; pp_idx = 2'd1; state_d = abort ? IDLE : P2;   end
         P2: begin in_pp = 1'b1; pp_idx = 2'd2; state_d = abort ? IDLE : P3;   end
         P3: begin in_pp = 1'b1; pp_idx = 2'd3; state_d = abort ? IDLE : DONE; end
         DONE: begin
            done       = 1'b1;
            ops_done_d = ops_done_q + 8'd1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort only changes the next state; outputs stay a pure decode of state.
      if (in_pp) begin
         step    = order_step(pp_idx);
         Asel    = step.a_sel;
         Bsel    = step.b_sel;
         ans_sel = step.ans_sel;
         busy    = 1'b1;
      end
   end

   assign ops_done = ops_done_q;

endmodule

// File: tb/tb_mult4_4_ctrl.sv
// Directed bench for mult4_4_ctrl: both partial-product orders, each driving a
// small behavioural accumulator so the final product can be checked.
module tb_mult4_4_ctrl;

   typedef struct {
      logic [3:0] in1;
      logic [3:0] in2;
      logic [7:0] prod;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_lo, abort_lo, start_hi, abort_hi;
   logic       asel_lo, bsel_lo, acc_clr_lo, busy_lo, done_lo;
   logic       asel_hi, bsel_hi, acc_clr_hi, busy_hi, done_hi;
   logic [1:0] ans_sel_lo, ans_sel_hi;
   logic [7:0] ops_done_lo, ops_done_hi;
   logic [3:0] in1_lo, in2_lo, in1_hi, in2_hi;
   logic [7:0] acc_lo, acc_hi;
   logic [6:0] outs_lo, outs_hi;
   int         n_checks = 0;
   int         n_fail = 0;

   // Output pattern {Asel, Bsel, ans_sel, acc_clr, busy, done} per state CLR..DONE.
   logic [6:0] seq_lo [6] = '{7'b0000110, 7'b0011010, 7'b0110010,
                              7'b1010010, 7'b1101010, 7'b0000001};
   logic [6:0] seq_hi [6] = '{7'b0000110, 7'b1101010, 7'b1010010,
                              7'b0110010, 7'b0011010, 7'b0000001};

   always #5 clk = ~clk;

   mult4_4_ctrl #(.HI_FIRST(1'b0)) u_lo (
      .clk(clk), .rst(rst), .start(start_lo), .abort(abort_lo),
      .Asel(asel_lo), .Bsel(bsel_lo), .ans_sel(ans_sel_lo), .acc_clr(acc_clr_lo),
      .busy(busy_lo), .done(done_lo), .ops_done(ops_done_lo)
   );

   mult4_4_ctrl #(.HI_FIRST(1'b1)) u_hi (
      .clk(clk), .rst(rst), .start(start_hi), .abort(abort_hi),
      .Asel(asel_hi), .Bsel(bsel_hi), .ans_sel(ans_sel_hi), .acc_clr(acc_clr_hi),
      .busy(busy_hi), .done(done_hi), .ops_done(ops_done_hi)
   );

   assign outs_lo = {asel_lo, bsel_lo, ans_sel_lo, acc_clr_lo, busy_lo, done_lo};
   assign outs_hi = {asel_hi, bsel_hi, ans_sel_hi, acc_clr_hi, busy_hi, done_hi};

   function automatic logic [7:0] pp_term(input logic [3:0] a, input logic [3:0] b,
                                          input logic asel, input logic bsel,
                                          input logic [1:0] sel);
      logic [1:0] ah, bh;
      logic [3:0] p;
      ah = asel ? a[3:2] : a[1:0];
      bh = bsel ? b[3:2] : b[1:0];
      p  = 4'(ah) * 4'(bh);
      case (sel)
         2'd1:    return {p, 4'b0000};
         2'd2:    return {2'b00, p, 2'b00};
         2'd3:    return {4'b0000, p};
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_lo <= '0;
         acc_hi <= '0;
      end else begin
         acc_lo <= acc_clr_lo ? 8'h00 : acc_lo + pp_term(in1_lo, in2_lo, asel_lo, bsel_lo, ans_sel_lo);
         acc_hi <= acc_clr_hi ? 8'h00 : acc_hi + pp_term(in1_hi, in2_hi, asel_hi, bsel_hi, ans_sel_hi);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op_lo(input logic [3:0] a, input logic [3:0] b,
                            output int lat, output logic [7:0] prod);
      in1_lo   = a;
      in2_lo   = b;
      start_lo = 1'b1;
      tick();
      start_lo = 1'b0;
      lat = 1;
      while (!done_lo && lat < 20) begin
         tick();
         lat++;
      end
      prod = acc_lo;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [8];
      int         lat, cnt, cyc, first_at, second_at, exp_ops;
      logic [7:0] prod;

      vecs = '{'{4'hF, 4'hF, 8'hE1}, '{4'h3, 4'h5, 8'h0F}, '{4'h6, 4'h9, 8'h36},
               '{4'h0, 4'hF, 8'h00}, '{4'hA, 4'hB, 8'h6E}, '{4'h7, 4'h7, 8'h31},
               '{4'hC, 4'h3, 8'h24}, '{4'h1, 4'h1, 8'h01}};

      rst = 1'b0;
      start_lo = 1'b0; abort_lo = 1'b0; start_hi = 1'b0; abort_hi = 1'b0;
      in1_lo = '0; in2_lo = '0; in1_hi = '0; in2_hi = '0;
      #7;
      check("reset_outs_lo", outs_lo, 7'd0);
      check("reset_outs_hi", outs_hi, 7'd0);
      check("reset_ops_lo", ops_done_lo, 8'd0);
      #5 rst = 1'b1;
      tick();
      check("idle_outs_lo", outs_lo, 7'd0);

      // 15x15 low-first with full per-state select trace
      in1_lo = 4'hF; in2_lo = 4'hF; start_lo = 1'b1;
      tick();
      start_lo = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("ff_seq_lo[%0d]", i), outs_lo, seq_lo[i]);
         if (i == 5) check("ff_product", acc_lo, 8'hE1);
         else tick();
      end
      tick();
      check("ff_back_idle", outs_lo, 7'd0);
      check("ff_ops", ops_done_lo, 8'd1);
      exp_ops = 1;

      // 6x9 high-first with select trace
      in1_hi = 4'h6; in2_hi = 4'h9; start_hi = 1'b1;
      tick();
      start_hi = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("hi_seq[%0d]", i), outs_hi, seq_hi[i]);
         if (i == 5) check("hi_product", acc_hi, 8'h36);
         else tick();
      end
      tick();
      check("hi_ops", ops_done_hi, 8'd1);

      for (int v = 0; v < 8; v++) begin
         run_op_lo(vecs[v].in1, vecs[v].in2, lat, prod);
         exp_ops++;
         check($sformatf("vec%0d_latency", v), lat, 6);
         check($sformatf("vec%0d_product", v), prod, vecs[v].prod);
         check($sformatf("vec%0d_ops", v), ops_done_lo, exp_ops[7:0]);
      end

      // start held for 12 edges: extra starts while busy/DONE are ignored
      in1_lo = 4'h2; in2_lo = 4'h3; start_lo = 1'b1;
      cnt = 0; first_at = 0; second_at = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 12) start_lo = 1'b0;
         if (done_lo) begin
            cnt++;
            if (cnt == 1) first_at = c;
            else if (cnt == 2) second_at = c;
         end
      end
      exp_ops += 2;
      check("held_done_count", cnt, 2);
      check("held_first_done", first_at, 6);
      check("held_done_gap", second_at - first_at, 7);
      check("held_product", acc_lo, 8'h06);
      check("held_ops", ops_done_lo, exp_ops[7:0]);

      // abort in P1
      start_lo = 1'b1;
      tick();
      start_lo = 1'b0;
      tick();
      tick();
      check("abort_in_p1", outs_lo, seq_lo[2]);
      abort_lo = 1'b1;
      tick();
      abort_lo = 1'b0;
      check("abort_to_idle", outs_lo, 7'd0);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done_lo) cnt++;
      end
      check("abort_no_done", cnt, 0);
      check("abort_ops", ops_done_lo, exp_ops[7:0]);

      // start and abort together in IDLE: start wins; abort in DONE is ignored
      start_lo = 1'b1; abort_lo = 1'b1;
      tick();
      start_lo = 1'b0; abort_lo = 1'b0;
      check("start_beats_abort", outs_lo, seq_lo[0]);
      cyc = 1;
      while (!done_lo && cyc < 20) begin
         tick();
         cyc++;
      end
      check("start_abort_latency", cyc, 6);
      abort_lo = 1'b1;
      tick();
      abort_lo = 1'b0;
      exp_ops++;
      check("abort_in_done_ops", ops_done_lo, exp_ops[7:0]);

      // reset during P2
      in1_lo = 4'h3; in2_lo = 4'h5; start_lo = 1'b1;
      tick();
      start_lo = 1'b0;
      tick(); tick(); tick();
      check("pre_reset_p2", outs_lo, seq_lo[3]);
      #2 rst = 1'b0;
      #1;
      check("midop_reset_outs", outs_lo, 7'd0);
      check("midop_reset_ops", ops_done_lo, 8'd0);
      check("midop_reset_ops_hi", ops_done_hi, 8'd0);
      #1 rst = 1'b1;
      tick();
      check("post_reset_idle", outs_lo, 7'd0);
      run_op_lo(4'h3, 4'h5, lat, prod);
      check("post_reset_latency", lat, 6);
      check("post_reset_product", prod, 8'h0F);
      check("post_reset_ops", ops_done_lo, 8'd1);

      // 256 back-to-back operations from a fresh reset
      #2 rst = 1'b0;
      #1 rst = 1'b1;
      tick();
      start_lo = 1'b1;
      for (int k = 0; k < 256; k++) begin
         cyc = 0;
         do begin
            tick();
            cyc++;
         end while (!done_lo && cyc < 20);
         check($sformatf("b2b_gap[%0d]", k), cyc, (k == 0) ? 6 : 7);
         if (k == 255) begin
            check("b2b_ops_before_wrap", ops_done_lo, 8'd255);
            start_lo = 1'b0;
         end
      end
      tick();
      check("b2b_ops_wrapped", ops_done_lo, 8'd0);
      check("b2b_idle", outs_lo, 7'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult4_4_ctrl.md
MULT4_4_CTRL -- requirements
Module: mult4_4_ctrl

Interface
REQ-001 Parameter HI_FIRST, default 0: sets the partial-product order; 0 gives LL,LH,HL,HH and 1 gives HH,HL,LH,LL.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 Asel  output  1  datapath operand-A half select: 0 = bits [1:0], 1 = bits [3:2].
REQ-007 Bsel  output  1  datapath operand-B half select: 0 = bits [1:0], 1 = bits [3:2].
REQ-008 ans_sel  output  2  accumulate-term select: 0 = zero, 1 = product<<4, 2 = product<<2, 3 = product unshifted.
REQ-009 acc_clr  output  1  one-cycle synchronous clear of the 8-bit datapath accumulator.
REQ-010 busy  output  1  high from start acceptance until the cycle before done.
REQ-011 done  output  1  one-cycle pulse; the accumulator holds the final 8-bit product.
REQ-012 ops_done  output  8  count of completed (non-aborted) multiplies.

Function
REQ-013 FSM states SHALL be IDLE, CLR, P0, P1, P2, P3, DONE; encodings SHALL be fixed in the package.
REQ-014 IDLE SHALL drive ans_sel=0, acc_clr=0, busy=0 and done=0, so the accumulator holds its value.
REQ-015 IDLE with start=1 at a rising edge SHALL move to CLR; the requester SHALL hold in1/in2 stable until done.
REQ-016 CLR SHALL drive acc_clr=1 and ans_sel=0 for exactly one cycle, then move to P0.
REQ-017 With HI_FIRST=0, P0..P3 SHALL drive (Asel,Bsel,ans_sel) = (0,0,3), (0,1,2), (1,0,2), (1,1,1) in that order.
REQ-018 With HI_FIRST=1, P0..P3 SHALL drive (1,1,1), (1,0,2), (0,1,2), (0,0,3) in that order.
REQ-019 Each Pn state SHALL last exactly one cycle; P3 SHALL move to DONE.
REQ-020 DONE SHALL drive done=1 and ans_sel=0, increment ops_done (wrapping 255 to 0), and move to IDLE.
REQ-021 Latency SHALL be fixed: done is high in the 6th cycle after the start-sampling edge.
REQ-022 start asserted while busy or in DONE SHALL be ignored; a new start is accepted only in IDLE.
REQ-023 abort=1 in CLR or any Pn SHALL move to IDLE at the next edge, with ans_sel=0 that cycle, no done pulse and no ops_done change.
REQ-024 abort in IDLE or DONE SHALL have no effect; if start and abort are both high in IDLE, start SHALL win.
REQ-025 All outputs SHALL be registered or decoded from state only; no input-to-output combinational path.
REQ-026 Selects in IDLE SHALL be Asel=0 and Bsel=0.

Reset
REQ-027 rst low SHALL immediately force IDLE, ops_done=0, Asel=0, Bsel=0, ans_sel=0, acc_clr=0, busy=0 and done=0.
REQ-028 Reset mid-operation SHALL discard the operation; the next operation SHALL start only from a fresh start in IDLE.

Structure
REQ-029 Package mult_ctrl_pkg SHALL hold the state enum, the ans_sel encodings (SEL_ZERO, SEL_SHL4, SEL_SHL2, SEL_NOSH) and the product-order table.
REQ-030 The block SHALL be a single module with no sub-module; the top level SHALL wire acc_clr into the accumulator clear path alongside reset.

Verification
REQ-031 in1=4'hF, in2=4'hF, one start pulse -> done in the 6th cycle and product output = 8'hE1.
REQ-032 in1=4'h6, in2=4'h9 with HI_FIRST=1 -> output 8'h36; select sequence matches REQ-018.
REQ-033 start held high for 12 cycles -> exactly two done pulses, 7 cycles apart.
REQ-034 abort asserted in P1 -> IDLE at next edge, no done pulse, ops_done unchanged.
REQ-035 rst low during P2 -> all outputs 0 immediately; next start with 3x5 -> 8'h0F.
REQ-036 256 back-to-back operations -> ops_done wraps to 0.
